// File: rtl/sumador_acumulador_if.sv
// rtl/sumador_acumulador_if.sv - operand stream in, sum/flags out, with valid/ready and valid/ack handshakes
interface sumador_acumulador_if #(
  parameter int WIDTH = 4
);
  logic             iCarry0;
  logic             iValid;
  logic [WIDTH-1:0] iOperand;
  logic             oReady;
  logic             iClear;
  logic             oValid;
  logic [WIDTH+1:0] oSum;
  logic             oCarry;
  logic             oOverflow;
  logic             iAck;

  modport slave (
    input  iCarry0, iValid, iOperand, iClear, iAck,
    output oReady, oValid, oSum, oCarry, oOverflow
  );

  modport master (
    output iCarry0, iValid, iOperand, iClear, iAck,
    input  oReady, oValid, oSum, oCarry, oOverflow
  );
endinterface

// File: rtl/sumador_acumulador.sv
// rtl/sumador_acumulador.sv - sequential four-operand accumulator with carry-in, carry-out and overflow
module sumador_acumulador #(
  parameter int WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  sumador_acumulador_if.slave   bus
);
  localparam int N_OPS = 4;
  localparam int SW    = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [2:0]      count_q, count_d;
  logic [SW-1:0]   operand_ext;
  logic [SW-1:0]   carry_ext;

  assign operand_ext = {2'b00, bus.iOperand};
  assign carry_ext   = {{(SW-1){1'b0}}, bus.iCarry0};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iClear) begin
          acc_d   = '0;
          count_d = '0;
        end else if (bus.iValid) begin
          acc_d   = operand_ext + carry_ext;
          count_d = 3'd1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Clear wins over a same-cycle operand, which is dropped.
        if (bus.iClear) begin
          acc_d   = '0;
          count_d = '0;
          state_d = S_IDLE;
        end else if (bus.iValid) begin
          acc_d   = acc_q + operand_ext;
          count_d = count_q + 3'd1;
          if (count_q == 3'(N_OPS - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.iAck) begin
          acc_d   = '0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only.
  assign bus.oReady    = (state_q != S_DONE);
  assign bus.oValid    = (state_q == S_DONE);
  assign bus.oSum      = acc_q;
  assign bus.oCarry    = acc_q[WIDTH];
  assign bus.oOverflow = |acc_q[SW-1:WIDTH];
endmodule
